rob_pr_free_funnel: RTL and testbench

ROB_PR_FREE_FUNNEL -- requirements
Module: rob_pr_free_funnel

---
 rtl/rob_pr_free_funnel.sv | 135 +++++++++++++
 tb/tb_rob_pr_free_funnel.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rob_pr_free_funnel.sv
// rob_pr_free_funnel
//   Funnels commit groups of freed physical registers from the ROB into the
//   banked free list. Each group is held in a small circular FIFO together with
//   a per-lane "remaining" mask. Every cycle the head group offers, for each
//   bank, the lowest-index remaining lane whose PR maps to that bank
//   (bank = PR low bits). A group is popped in the cycle its last remaining
//   lanes are handshaken.
//
// Ports
//   CLK, nRST        clock, asynchronous active-low reset
//   enq_valid        ROB presents a commit group
//   enq_lane_valid   per-lane freed-PR valid mask   [LANES]
//   enq_lane_PR      per-lane freed PR, lane l at [l*7 +: 7]
//   enq_ready        a group can be accepted (registered count < ENTRIES)
//   deq_bank_valid   PR offered to free-list bank b [BANKS]
//   deq_bank_PR      offered PR, bank b at [b*7 +: 7], zero when not valid
//   deq_bank_ready   free-list bank b accepts the offered PR
module rob_pr_free_funnel #(
    parameter int unsigned ENTRIES = 2,
    parameter int unsigned LANES   = 4,
    parameter int unsigned BANKS   = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 enq_valid,
    input  logic [LANES-1:0]     enq_lane_valid,
    input  logic [LANES*7-1:0]   enq_lane_PR,
    output logic                 enq_ready,
    output logic [BANKS-1:0]     deq_bank_valid,
    output logic [BANKS*7-1:0]   deq_bank_PR,
    input  logic [BANKS-1:0]     deq_bank_ready
);

    localparam int unsigned PtrW  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int unsigned CntW  = $clog2(ENTRIES + 1);
    localparam int unsigned BankW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [PtrW-1:0]                     head_q, head_d;
    logic [PtrW-1:0]                     tail_q, tail_d;
    logic [CntW-1:0]                     count_q, count_d;
    logic [ENTRIES-1:0][LANES-1:0]       mask_q, mask_d;
    logic [ENTRIES-1:0][LANES-1:0][6:0]  pr_q, pr_d;

    logic [LANES-1:0]                    head_mask;
    logic [LANES-1:0][6:0]               head_pr;
    logic [LANES-1:0]                    clr_mask;
    logic [LANES-1:0]                    remaining;
    logic [BANKS-1:0]                    bank_valid;
    logic [BANKS-1:0][6:0]               bank_pr;
    logic [BANKS-1:0][LaneW-1:0]         bank_sel;
    logic                                push;
    logic                                pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(ENTRIES - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // No full-queue bypass: a pop in this cycle does not open the queue.
    assign enq_ready = (count_q < CntW'(ENTRIES));

    // Groups with no valid lane are accepted but never stored.
    assign push = enq_valid & enq_ready & (|enq_lane_valid);

    // Per-bank lane select on the head group; lanes are scanned from the top so
    // the lowest-index matching lane wins.
    always_comb begin
        head_mask  = (count_q != '0) ? mask_q[head_q] : '0;
        head_pr    = pr_q[head_q];
        bank_valid = '0;
        bank_pr    = '0;
        bank_sel   = '0;
        for (int b = 0; b < BANKS; b++) begin
            for (int l = LANES - 1; l >= 0; l--) begin
                if (head_mask[l] && (head_pr[l][BankW-1:0] == BankW'(b))) begin
                    bank_valid[b] = 1'b1;
                    bank_pr[b]    = head_pr[l];
                    bank_sel[b]   = LaneW'(l);
                end
            end
        end
    end

    always_comb begin
        clr_mask = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (bank_valid[b] && deq_bank_ready[b]) begin
                clr_mask[bank_sel[b]] = 1'b1;
            end
        end
        remaining = head_mask & ~clr_mask;
        pop       = (count_q != '0) && (remaining == '0);
    end

    always_comb begin
        mask_d  = mask_q;
        pr_d    = pr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CntW'(push) - CntW'(pop);
        if (count_q != '0) begin
            mask_d[head_q] = remaining;
        end
        // When both are active the queue is neither empty nor full, so the
        // tail slot is never the head slot.
        if (push) begin
            mask_d[tail_q] = enq_lane_valid;
            pr_d[tail_q]   = enq_lane_PR;
            tail_d         = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            mask_q  <= '0;
            pr_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mask_q  <= mask_d;
            pr_q    <= pr_d;
        end
    end

    assign deq_bank_valid = bank_valid;
    assign deq_bank_PR    = bank_pr;

endmodule

// File: tb/tb_rob_pr_free_funnel.sv
module tb_rob_pr_free_funnel;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        enq_valid;
    logic [3:0]  enq_lane_valid;
    logic [27:0] enq_lane_PR;
    logic        enq_ready;
    logic [3:0]  deq_bank_valid;
    logic [27:0] deq_bank_PR;
    logic [3:0]  deq_bank_ready;

    rob_pr_free_funnel #(
        .ENTRIES(2),
        .LANES  (4),
        .BANKS  (4)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .enq_valid     (enq_valid),
        .enq_lane_valid(enq_lane_valid),
        .enq_lane_PR   (enq_lane_PR),
        .enq_ready     (enq_ready),
        .deq_bank_valid(deq_bank_valid),
        .deq_bank_PR   (deq_bank_PR),
        .deq_bank_ready(deq_bank_ready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic            ev;
        logic [3:0]      lv;
        logic [27:0]     pr;
        logic [3:0]      rdy;
        logic            x_er;
        logic [3:0]      x_bv;
        logic [27:0]     x_bp;
    } vec_t;

    vec_t        vq[$];
    int          checks = 0;
    int          errors = 0;
    logic [6:0]  sbq[4][$];
    logic [3:0]  prev_v;
    logic [3:0]  prev_r;
    logic [27:0] prev_pr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic ev, input logic [3:0] lv, input logic [27:0] pr,
                       input logic [3:0] rdy, input logic x_er, input logic [3:0] x_bv,
                       input logic [27:0] x_bp);
        vec_t v;
        v.ev = ev; v.lv = lv; v.pr = pr; v.rdy = rdy;
        v.x_er = x_er; v.x_bv = x_bv; v.x_bp = x_bp;
        vq.push_back(v);
    endtask

    // One random/drain cycle with scoreboard and stall-stability checks.
    task automatic rand_step(input logic ev, input logic [3:0] lv, input logic [27:0] pr,
                             input logic [3:0] rdy);
        logic [6:0] got;
        @(negedge CLK);
        enq_valid      = ev;
        enq_lane_valid = lv;
        enq_lane_PR    = pr;
        deq_bank_ready = rdy;
        #1;
        for (int b = 0; b < 4; b++) begin
            got = deq_bank_PR[b*7 +: 7];
            if (prev_v[b] && !prev_r[b]) begin
                chk($sformatf("stall_valid_b%0d", b), 32'(deq_bank_valid[b]), 32'd1);
                chk($sformatf("stall_pr_b%0d", b), 32'(got), 32'(prev_pr[b*7 +: 7]));
            end
            if (deq_bank_valid[b]) begin
                if (sbq[b].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_extra_b%0d got %0h expected none", b, got);
                end else begin
                    chk($sformatf("rand_pr_b%0d", b), 32'(got), 32'(sbq[b][0]));
                    if (rdy[b]) void'(sbq[b].pop_front());
                end
            end
        end
        prev_v  = deq_bank_valid;
        prev_r  = rdy;
        prev_pr = deq_bank_PR;
        if (ev && enq_ready) begin
            for (int l = 0; l < 4; l++) begin
                if (lv[l]) sbq[pr[l*7 +: 2]].push_back(pr[l*7 +: 7]);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int total;
        nRST           = 1'b0;
        enq_valid      = 1'b0;
        enq_lane_valid = '0;
        enq_lane_PR    = '0;
        deq_bank_ready = '0;
        repeat (2) @(negedge CLK);
        #1;
        chk("reset_er", 32'(enq_ready), 32'd1);
        chk("reset_bv", 32'(deq_bank_valid), 32'd0);
        chk("reset_bp", 32'(deq_bank_PR), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // Single group, all banks distinct.
        add(1, 4'hF, {7'h13, 7'h0E, 7'h09, 7'h04}, 4'hF, 1, 4'h0, '0);
        add(0, 4'h0, '0, 4'hF, 1, 4'hF, {7'h13, 7'h0E, 7'h09, 7'h04});
        add(0, 4'h0, '0, 4'hF, 1, 4'h0, '0);
        // Bank conflict on bank 0.
        add(1, 4'hF, {7'h01, 7'h10, 7'h0C, 7'h08}, 4'hF, 1, 4'h0, '0);
        add(0, 4'h0, '0, 4'hF, 1, 4'b0011, {7'h00, 7'h00, 7'h01, 7'h08});
        add(0, 4'h0, '0, 4'hF, 1, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h0C});
        add(0, 4'h0, '0, 4'hF, 1, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h10});
        add(0, 4'h0, '0, 4'hF, 1, 4'h0, '0);
        // Full queue with backpressure, third group waits for a pop.
        add(1, 4'hF, {7'h04, 7'h03, 7'h02, 7'h01}, 4'h0, 1, 4'h0, '0);
        add(1, 4'hF, {7'h08, 7'h07, 7'h06, 7'h05}, 4'h0, 1, 4'hF, {7'h03, 7'h02, 7'h01, 7'h04});
        add(1, 4'hF, {7'h0C, 7'h0B, 7'h0A, 7'h09}, 4'h0, 0, 4'hF, {7'h03, 7'h02, 7'h01, 7'h04});
        add(1, 4'hF, {7'h0C, 7'h0B, 7'h0A, 7'h09}, 4'h0, 0, 4'hF, {7'h03, 7'h02, 7'h01, 7'h04});
        add(1, 4'hF, {7'h0C, 7'h0B, 7'h0A, 7'h09}, 4'hF, 0, 4'hF, {7'h03, 7'h02, 7'h01, 7'h04});
        add(1, 4'hF, {7'h0C, 7'h0B, 7'h0A, 7'h09}, 4'h0, 1, 4'hF, {7'h07, 7'h06, 7'h05, 7'h08});
        add(0, 4'h0, '0, 4'hF, 0, 4'hF, {7'h07, 7'h06, 7'h05, 7'h08});
        add(0, 4'h0, '0, 4'hF, 1, 4'hF, {7'h0B, 7'h0A, 7'h09, 7'h0C});
        // Filler group to line the pointers up; masked lanes carry junk.
        add(1, 4'b0001, {7'h7F, 7'h7E, 7'h7D, 7'h24}, 4'hF, 1, 4'h0, '0);
        add(0, 4'h0, '0, 4'hF, 1, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h24});
        // count=1, then enq+pop with tail wrapping 1->0, then an empty-mask group.
        add(1, 4'b0011, {7'h7D, 7'h7C, 7'h16, 7'h11}, 4'h0, 1, 4'h0, '0);
        add(1, 4'b0011, {7'h7F, 7'h7E, 7'h20, 7'h1B}, 4'hF, 1, 4'b0110,
            {7'h00, 7'h16, 7'h11, 7'h00});
        add(1, 4'h0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'h0, 1, 4'b1001,
            {7'h1B, 7'h00, 7'h00, 7'h20});
        add(0, 4'h0, '0, 4'hF, 1, 4'b1001, {7'h1B, 7'h00, 7'h00, 7'h20});
        add(0, 4'h0, '0, 4'hF, 1, 4'h0, '0);

        foreach (vq[i]) begin
            @(negedge CLK);
            enq_valid      = vq[i].ev;
            enq_lane_valid = vq[i].lv;
            enq_lane_PR    = vq[i].pr;
            deq_bank_ready = vq[i].rdy;
            #1;
            chk($sformatf("vec%0d_er", i), 32'(enq_ready), 32'(vq[i].x_er));
            chk($sformatf("vec%0d_bv", i), 32'(deq_bank_valid), 32'(vq[i].x_bv));
            chk($sformatf("vec%0d_bp", i), 32'(deq_bank_PR), 32'(vq[i].x_bp));
        end

        // Reset in the middle of draining a conflicting group.
        @(negedge CLK);
        enq_valid      = 1'b1;
        enq_lane_valid = 4'hF;
        enq_lane_PR    = {7'h01, 7'h10, 7'h0C, 7'h08};
        deq_bank_ready = 4'hF;
        @(negedge CLK);
        enq_valid = 1'b0;
        #1;
        chk("rst_pre_bv", 32'(deq_bank_valid), 32'b0011);
        chk("rst_pre_bp", 32'(deq_bank_PR), 32'({7'h00, 7'h00, 7'h01, 7'h08}));
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("rst_bv", 32'(deq_bank_valid), 32'd0);
        chk("rst_bp", 32'(deq_bank_PR), 32'd0);
        chk("rst_er", 32'(enq_ready), 32'd1);
        @(posedge CLK);
        #1;
        chk("rst_hold_bv", 32'(deq_bank_valid), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("post_rst%0d_bv", k), 32'(deq_bank_valid), 32'd0);
            chk($sformatf("post_rst%0d_er", k), 32'(enq_ready), 32'd1);
        end

        // Random traffic against a per-bank FIFO scoreboard.
        prev_v  = '0;
        prev_r  = '0;
        prev_pr = '0;
        for (int c = 0; c < 600; c++) begin
            rand_step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      28'($urandom), 4'($urandom_range(0, 15)));
        end
        for (int c = 0; c < 40; c++) begin
            rand_step(1'b0, 4'h0, '0, 4'hF);
        end
        total = sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size();
        chk("rand_drained", 32'(total), 32'd0);
        chk("rand_idle_bv", 32'(deq_bank_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
